soc_system_spi_slave: RTL and testbench

- SPI slave (responder) for the soc_system SPI bus: the target end of the soc_system SPI master link; mode 0 (CPOL=0, CPHA=0), MSB first.
- External SCLK/SS_n/MOSI are oversampled on clk; no SCLK-domain logic.
- CPU side is the same 3-bit-address, two-cycle-strobe register port as the SPI master, so one driver style serves both ends.

---
 rtl/soc_system_spi_slave_if.sv | 23 ++
 rtl/soc_system_spi_slave.sv | 265 ++++++++++++++++++++++++++
 tb/tb_soc_system_spi_slave.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/soc_system_spi_slave_if.sv
// CPU-side register port of the soc_system SPI slave: 3-bit address, two-cycle strobes, flag outputs.
interface soc_system_spi_slave_if;
  logic        spi_select;
  logic [2:0]  mem_addr;
  logic        read_n;
  logic        write_n;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu;
  logic        dataavailable;
  logic        readyfordata;
  logic        endofpacket;
  logic        irq;

  modport master (
    output spi_select, mem_addr, read_n, write_n, data_from_cpu,
    input  data_to_cpu, dataavailable, readyfordata, endofpacket, irq
  );

  modport slave (
    input  spi_select, mem_addr, read_n, write_n, data_from_cpu,
    output data_to_cpu, dataavailable, readyfordata, endofpacket, irq
  );
endinterface

// File: rtl/soc_system_spi_slave.sv
// Mode-0 MSB-first SPI slave, pins oversampled on clk (edge lag SYNC_STAGES+1); no backpressure, overruns flagged via TOE/ROE.
// Register reads valid one cycle after the strobe; SOC_SYSTEM_SPI_SLAVE_RXFIFO_EN swaps rx_hold for a 4-entry RX FIFO.
module soc_system_spi_slave #(
  parameter int DATABITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCLK,
  input  logic                  SS_n,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_oe,
  soc_system_spi_slave_if.slave bus
);
  localparam int CW = $clog2(DATABITS + 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;
  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
  logic r_sclk_prev, r_ss_prev;
  logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise, w_mosi;

  logic [DATABITS-1:0] r_shift, r_tx_hold, r_eop_val, w_shift_nxt, w_rx_data;
  logic [CW-1:0]       r_bit_cnt;
  logic                r_miso, r_reload_pend, r_tx_primed;
  logic                r_toe, r_roe, r_eop, r_irq, r_strobe, r_rx_rd;
  logic [15:0]         r_ctrl, r_rdata, w_rdata, w_status;
  logic [2:0]          w_level;
  logic                w_busy, w_oe, w_rrdy, w_trdy, w_tmt;
  logic                w_stb, w_wr, w_rd, w_wr_tx, w_wr_stat;
  logic                w_load, w_abort, w_rise, w_fall, w_done, w_reload, w_take, w_eop_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_ss_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
      r_ss_prev   <= r_ss_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
  assign w_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_prev;
  assign w_ss_fall   = ~r_ss_sync[SYNC_STAGES-1] & r_ss_prev;
  assign w_ss_rise   = r_ss_sync[SYNC_STAGES-1] & ~r_ss_prev;
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];

  // One strobe per access: r_strobe stays set while the CPU holds its strobe.
  assign w_stb     = bus.spi_select & (~bus.read_n | ~bus.write_n) & ~r_strobe;
  assign w_wr      = w_stb & ~bus.write_n;
  assign w_rd      = w_stb & ~bus.read_n;
  assign w_wr_tx   = w_wr & (bus.mem_addr == 3'd1);
  assign w_wr_stat = w_wr & (bus.mem_addr == 3'd2);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_oe        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ss_fall) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        w_busy = 1'b1;
        w_oe   = 1'b1;
        if (w_ss_rise) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  generate
    if (DATABITS == 1) begin : g_shift_one
      assign w_shift_nxt = w_mosi;
    end else begin : g_shift_many
      assign w_shift_nxt = {r_shift[DATABITS-2:0], w_mosi};
    end
  endgenerate

  assign w_load   = (r_state == S_IDLE) & w_ss_fall;
  assign w_abort  = (r_state == S_SHIFT) & w_ss_rise;
  assign w_rise   = (r_state == S_SHIFT) & ~w_ss_rise & w_sclk_rise;
  assign w_fall   = (r_state == S_SHIFT) & ~w_ss_rise & w_sclk_fall;
  assign w_done   = w_rise & (r_bit_cnt == CW'(DATABITS - 1));
  assign w_reload = w_load | (w_fall & r_reload_pend);
  assign w_take   = w_reload & r_tx_primed;

  // MISO is a separate flop so it only moves on SCLK falls, never on the sampling rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_miso        <= 1'b0;
      r_reload_pend <= 1'b0;
    end else if (w_abort) begin
      r_bit_cnt     <= '0;
      r_miso        <= 1'b0;
      r_reload_pend <= 1'b0;
    end else if (w_reload) begin
      r_shift       <= w_take ? r_tx_hold : '0;
      r_miso        <= w_take & r_tx_hold[DATABITS-1];
      r_reload_pend <= 1'b0;
    end else if (w_rise) begin
      r_shift <= w_shift_nxt;
      if (w_done) begin
        r_bit_cnt     <= '0;
        r_reload_pend <= 1'b1;
      end else begin
        r_bit_cnt <= r_bit_cnt + CW'(1);
      end
    end else if (w_fall) begin
      r_miso <= r_shift[DATABITS-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_hold   <= '0;
      r_tx_primed <= 1'b0;
    end else begin
      if (w_take) r_tx_primed <= 1'b0;
      if (w_wr_tx && !r_tx_primed) begin
        r_tx_hold   <= bus.data_from_cpu[DATABITS-1:0];
        r_tx_primed <= 1'b1;
      end
    end
  end

  assign w_eop_hit = (w_done & (w_shift_nxt == r_eop_val)) |
                     (w_wr_tx & (bus.data_from_cpu[DATABITS-1:0] == r_eop_val));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_toe     <= 1'b0;
      r_eop     <= 1'b0;
      r_ctrl    <= '0;
      r_eop_val <= '0;
      r_strobe  <= 1'b0;
      r_rx_rd   <= 1'b0;
    end else begin
      r_strobe <= bus.spi_select & (~bus.read_n | ~bus.write_n);
      r_rx_rd  <= w_rd & (bus.mem_addr == 3'd0);
      if (w_wr_stat) begin
        r_toe <= 1'b0;
        r_eop <= 1'b0;
      end else begin
        if (w_wr_tx && r_tx_primed) r_toe <= 1'b1;
        if (w_eop_hit)              r_eop <= 1'b1;
      end
      if (w_wr && bus.mem_addr == 3'd3) r_ctrl    <= bus.data_from_cpu & 16'h03D8;
      if (w_wr && bus.mem_addr == 3'd6) r_eop_val <= bus.data_from_cpu[DATABITS-1:0];
    end
  end

`ifdef SOC_SYSTEM_SPI_SLAVE_RXFIFO_EN
  logic [DATABITS-1:0] r_fifo [4];
  logic [1:0]          r_wp, r_rp;
  logic [2:0]          r_cnt;
  logic                w_pop, w_push;

  assign w_pop  = r_rx_rd & (r_cnt != 3'd0);
  assign w_push = w_done & ((r_cnt != 3'd4) | w_pop);

  // A status write flushes, but a byte completing in the same cycle still lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_fifo[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_roe <= 1'b0;
    end else if (w_wr_stat) begin
      r_rp  <= '0;
      r_roe <= 1'b0;
      r_wp  <= {1'b0, w_done};
      r_cnt <= {2'b00, w_done};
      if (w_done) r_fifo[0] <= w_shift_nxt;
    end else begin
      if (w_push) begin
        r_fifo[r_wp] <= w_shift_nxt;
        r_wp         <= r_wp + 2'd1;
      end
      if (w_pop) r_rp <= r_rp + 2'd1;
      r_cnt <= r_cnt + {2'b00, w_push} - {2'b00, w_pop};
      if (w_done && !w_push) r_roe <= 1'b1;
    end
  end

  assign w_rx_data = r_fifo[r_rp];
  assign w_rrdy    = (r_cnt != 3'd0);
  assign w_level   = r_cnt;
`else
  logic [DATABITS-1:0] r_rx_hold;
  logic                r_rrdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_hold <= '0;
      r_rrdy    <= 1'b0;
      r_roe     <= 1'b0;
    end else begin
      if (w_done) r_rx_hold <= w_shift_nxt;
      if (w_wr_stat) begin
        r_rrdy <= w_done;
        r_roe  <= 1'b0;
      end else begin
        if (w_done)       r_rrdy <= 1'b1;
        else if (r_rx_rd) r_rrdy <= 1'b0;
        if (w_done && r_rrdy && !r_rx_rd) r_roe <= 1'b1;
      end
    end
  end

  assign w_rx_data = r_rx_hold;
  assign w_rrdy    = r_rrdy;
  assign w_level   = 3'd0;
`endif

  assign w_trdy   = ~r_tx_primed;
  assign w_tmt    = ~w_busy & ~r_tx_primed;
  assign w_status = {6'b0, r_eop, r_toe | r_roe, w_rrdy, w_trdy, w_tmt, r_toe, r_roe, w_level};

  always_comb begin
    w_rdata = '0;
    case (bus.mem_addr)
      3'd0:    w_rdata[DATABITS-1:0] = w_rx_data;
      3'd2:    w_rdata = w_status;
      3'd3:    w_rdata = r_ctrl;
      3'd6:    w_rdata[DATABITS-1:0] = r_eop_val;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (w_rd) r_rdata <= w_rdata;
      r_irq <= |(w_status & r_ctrl);
    end
  end

  assign MISO              = r_miso;
  assign MISO_oe           = w_oe;
  assign bus.data_to_cpu   = r_rdata;
  assign bus.dataavailable = w_rrdy;
  assign bus.readyfordata  = w_trdy;
  assign bus.endofpacket   = r_eop;
  assign bus.irq           = r_irq;
endmodule

// File: tb/tb_soc_system_spi_slave.sv
// Directed bench for soc_system_spi_slave: CPU register accesses plus a clk/8 mode-0 SPI master model.
module tb_soc_system_spi_slave;
`ifdef SOC_SYSTEM_SPI_SLAVE_RXFIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic SCLK = 1'b0;
  logic SS_n = 1'b1;
  logic MOSI = 1'b0;
  logic MISO, MISO_oe;
  int   n_cmp = 0;
  int   n_err = 0;

  soc_system_spi_slave_if bus ();

  soc_system_spi_slave #(.DATABITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lv(input int n);
    return FIFO_EN ? 16'(n) : 16'd0;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.spi_select = 1'b1; bus.mem_addr = a; bus.data_from_cpu = d; bus.write_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.write_n = 1'b1; bus.spi_select = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.spi_select = 1'b1; bus.mem_addr = a; bus.read_n = 1'b0;
    @(negedge clk);
    d = bus.data_to_cpu;
    @(negedge clk);
    bus.read_n = 1'b1; bus.spi_select = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] d;
    cpu_read(a, d);
    chk(tag, d, exp);
  endtask

  task automatic spi_xfer(input logic [7:0] mo, output logic [7:0] mi);
    @(negedge clk);
    SS_n = 1'b0; MOSI = mo[7];
    repeat (8) @(negedge clk);
    chk("miso_oe_in_frame", {15'd0, MISO_oe}, 16'd1);
    for (int i = 7; i >= 0; i--) begin
      MOSI = mo[i];
      repeat (4) @(negedge clk);
      SCLK = 1'b1;
      mi[i] = MISO;
      repeat (4) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (4) @(negedge clk);
    SS_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mi;
    bus.spi_select = 1'b0; bus.mem_addr = 3'd0; bus.read_n = 1'b1; bus.write_n = 1'b1;
    bus.data_from_cpu = 16'd0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("reset_irq", {15'd0, bus.irq}, 16'd0);
    chk("reset_miso_oe", {15'd0, MISO_oe}, 16'd0);
    chk("reset_dataavailable", {15'd0, bus.dataavailable}, 16'd0);
    chk("reset_data_to_cpu", bus.data_to_cpu, 16'd0);
    chk_reg("reset_status", 3'd2, 16'h0060);

    // Basic frame: slave sends 0xA5, master sends 0x3C.
    cpu_write(3'd1, 16'h00A5);
    chk_reg("primed_status", 3'd2, 16'h0000);
    chk("primed_readyfordata", {15'd0, bus.readyfordata}, 16'd0);
    spi_xfer(8'h3C, mi);
    chk("miso_byte_a5", {8'd0, mi}, 16'h00A5);
    chk_reg("rx_status_rrdy", 3'd2, 16'h00E0 | lv(1));
    chk("dataavailable_set", {15'd0, bus.dataavailable}, 16'd1);
    chk_reg("rxdata_3c", 3'd0, 16'h003C);
    chk_reg("status_after_read", 3'd2, 16'h0060);

    // Two frames without a read: overrun in single-holding mode.
    spi_xfer(8'h11, mi);
    chk("underrun_miso_zero", {8'd0, mi}, 16'h0000);
    spi_xfer(8'h22, mi);
    chk_reg("overrun_status", 3'd2, FIFO_EN ? (16'h00E0 | lv(2)) : 16'h01E8);
    cpu_write(3'd3, 16'h0100);
    chk_reg("control_readback", 3'd3, 16'h0100);
    chk("irq_on_e", {15'd0, bus.irq}, FIFO_EN ? 16'd0 : 16'd1);
    chk_reg("rxdata_after_overrun", 3'd0, FIFO_EN ? 16'h0011 : 16'h0022);
    cpu_write(3'd2, 16'hFFFF);
    chk_reg("status_cleared", 3'd2, 16'h0060);
    chk("irq_cleared", {15'd0, bus.irq}, 16'd0);

    // Second txdata write while primed is dropped and raises TOE.
    cpu_write(3'd1, 16'h0001);
    cpu_write(3'd1, 16'h0002);
    chk_reg("toe_status", 3'd2, 16'h0110);
    chk("irq_on_toe", {15'd0, bus.irq}, 16'd1);
    spi_xfer(8'h33, mi);
    chk("miso_first_write_kept", {8'd0, mi}, 16'h0001);
    chk_reg("toe_after_frame", 3'd2, 16'h01F0 | lv(1));
    chk_reg("rxdata_33", 3'd0, 16'h0033);
    cpu_write(3'd2, 16'h0000);
    cpu_write(3'd3, 16'h0000);

    // Partial frame (4 rises) is discarded; the next full frame is clean.
    @(negedge clk);
    SS_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      MOSI = i[0];
      repeat (4) @(negedge clk); SCLK = 1'b1;
      repeat (4) @(negedge clk); SCLK = 1'b0;
    end
    repeat (4) @(negedge clk);
    SS_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("partial_miso_oe_low", {15'd0, MISO_oe}, 16'd0);
    chk_reg("partial_no_rrdy", 3'd2, 16'h0060);
    spi_xfer(8'h7E, mi);
    chk_reg("rxdata_7e", 3'd0, 16'h007E);

    // End-of-packet match on received data and on a txdata write.
    cpu_write(3'd6, 16'h0055);
    chk_reg("eop_value_readback", 3'd6, 16'h0055);
    spi_xfer(8'h55, mi);
    chk("endofpacket_rx", {15'd0, bus.endofpacket}, 16'd1);
    chk_reg("eop_status", 3'd2, 16'h02E0 | lv(1));
    cpu_write(3'd2, 16'h0000);
    chk("endofpacket_cleared", {15'd0, bus.endofpacket}, 16'd0);
    cpu_write(3'd1, 16'h0055);
    chk("endofpacket_tx", {15'd0, bus.endofpacket}, 16'd1);
    chk_reg("unmapped_addr_reads_zero", 3'd5, 16'h0000);

    // Reset in the middle of a frame.
    @(negedge clk);
    SS_n = 1'b0;
    repeat (8) @(negedge clk);
    chk("midframe_oe_high", {15'd0, MISO_oe}, 16'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("midframe_reset_oe_low", {15'd0, MISO_oe}, 16'd0);
    SS_n = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_reg("post_reset_status", 3'd2, 16'h0060);
    chk_reg("post_reset_eop_value", 3'd6, 16'h0000);

`ifdef SOC_SYSTEM_SPI_SLAVE_RXFIFO_EN
    for (int k = 1; k <= 5; k++) spi_xfer(8'(k), mi);
    chk_reg("fifo_full_status", 3'd2, 16'h01EC);
    for (int k = 1; k <= 4; k++) chk_reg("fifo_pop", 3'd0, 16'(k));
    chk("fifo_drained", {15'd0, bus.dataavailable}, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
